// File: rtl/bellek_yanitlayici.sv
// Memory bus responder: word-addressed RAM plus a peripheral window holding a
// free-running cycle counter, a status register and a byte TX FIFO drained on
// a valid/ready stream. Reads are combinational; writes commit on the edge.
module bellek_yanitlayici #(
  parameter logic [31:0] BELLEK_ADRES  = 32'h8000_0000,
  parameter int unsigned KELIME_SAYISI = 1024,
  parameter logic [31:0] CEVRE_ADRES   = 32'hC000_0000,
  parameter int unsigned FIFO_DERINLIK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bellek_adres,
  output logic [31:0] bellek_oku_veri,
  input  logic [31:0] bellek_yaz_veri,
  input  logic        bellek_yaz,
  output logic [7:0]  cikis_veri,
  output logic        cikis_gecerli,
  input  logic        cikis_hazir,
  output logic        hata
);

  localparam int unsigned AW = $clog2(KELIME_SAYISI);
  localparam int unsigned PW = $clog2(FIFO_DERINLIK);
  // 33-bit upper bound so a RAM placed at the top of the map cannot wrap.
  localparam logic [32:0] RAM_UST   = {1'b0, BELLEK_ADRES} + 33'(4 * KELIME_SAYISI);
  localparam logic [31:0] SAY_ADRES = CEVRE_ADRES;
  localparam logic [31:0] DUR_ADRES = CEVRE_ADRES + 32'd4;
  localparam logic [31:0] TX_ADRES  = CEVRE_ADRES + 32'd8;
  localparam logic [PW:0] DOLU_SAYI = (PW + 1)'(FIFO_DERINLIK);

  logic [31:0]   adr_s;
  logic          ram_sec_s;
  logic          say_sec_s;
  logic          dur_sec_s;
  logic          tx_sec_s;
  logic          gecersiz_s;

  logic [31:0]   ram_r [KELIME_SAYISI];
  logic [31:0]   sayac_r;

  logic [7:0]    fifo_r [FIFO_DERINLIK];
  logic [PW-1:0] oku_ptr_r;
  logic [PW-1:0] yaz_ptr_r;
  logic [PW:0]   doluluk_r;
  logic          tasma_r;
  logic          hata_r;
  logic          tx_onceki_r;

  logic          bos_s;
  logic          dolu_s;
  logic          pop_s;
  logic          push_dene_s;
  logic          push_s;
  logic          tasma_set_s;
  logic [31:0]   durum_s;

  assign adr_s      = bellek_adres & ~32'd3;
  assign ram_sec_s  = ({1'b0, adr_s} >= {1'b0, BELLEK_ADRES}) && ({1'b0, adr_s} < RAM_UST);
  assign say_sec_s  = (adr_s == SAY_ADRES);
  assign dur_sec_s  = (adr_s == DUR_ADRES);
  assign tx_sec_s   = (adr_s == TX_ADRES);
  assign gecersiz_s = !(ram_sec_s || say_sec_s || dur_sec_s || tx_sec_s);

  assign bos_s  = (doluluk_r == '0);
  assign dolu_s = (doluluk_r == DOLU_SAYI);

  // Pop is evaluated first, so a push into a full FIFO that pops this cycle fits.
  assign pop_s       = !bos_s && cikis_hazir;
  assign push_dene_s = bellek_yaz && tx_sec_s && !tx_onceki_r;
  assign push_s      = push_dene_s && (!dolu_s || pop_s);
  assign tasma_set_s = push_dene_s && dolu_s && !pop_s;

  assign durum_s = {16'h0000, 8'(doluluk_r), 4'h0, hata_r, tasma_r, dolu_s, bos_s};

  assign cikis_gecerli = !bos_s;
  assign cikis_veri    = bos_s ? 8'h00 : fifo_r[oku_ptr_r];
  assign hata          = hata_r;

  // Combinational read mux over the decoded regions; unmapped reads return 0.
  always_comb begin
    bellek_oku_veri = 32'h0000_0000;
    if (ram_sec_s) begin
      bellek_oku_veri = ram_r[adr_s[AW+1:2]];
    end else if (say_sec_s) begin
      bellek_oku_veri = sayac_r;
    end else if (dur_sec_s) begin
      bellek_oku_veri = durum_s;
    end else begin
      bellek_oku_veri = 32'h0000_0000;
    end
  end

  // RAM word write; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (bellek_yaz && ram_sec_s) begin
      ram_r[adr_s[AW+1:2]] <= bellek_yaz_veri;
    end
  end

  // Cycle counter: a bus write loads it, otherwise it increments and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sayac_r <= 32'h0000_0000;
    end else if (bellek_yaz && say_sec_s) begin
      sayac_r <= bellek_yaz_veri;
    end else begin
      sayac_r <= sayac_r + 32'd1;
    end
  end

  // FIFO byte storage; only accepted pushes land here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[yaz_ptr_r] <= bellek_yaz_veri[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oku_ptr_r <= '0;
      yaz_ptr_r <= '0;
      doluluk_r <= '0;
    end else begin
      if (pop_s) begin
        oku_ptr_r <= oku_ptr_r + PW'(1);
      end
      if (push_s) begin
        yaz_ptr_r <= yaz_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   doluluk_r <= doluluk_r + (PW + 1)'(1);
        2'b01:   doluluk_r <= doluluk_r - (PW + 1)'(1);
        default: doluluk_r <= doluluk_r;
      endcase
    end
  end

  // Remembers a TX write so a held strobe pushes only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_onceki_r <= 1'b0;
    end else begin
      tx_onceki_r <= bellek_yaz && tx_sec_s;
    end
  end

  // Sticky overflow and decode-error flags; setting beats a same-cycle W1C clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tasma_r <= 1'b0;
      hata_r  <= 1'b0;
    end else begin
      if (tasma_set_s) begin
        tasma_r <= 1'b1;
      end else if (bellek_yaz && dur_sec_s && bellek_yaz_veri[2]) begin
        tasma_r <= 1'b0;
      end
      if (gecersiz_s) begin
        hata_r <= 1'b1;
      end else if (bellek_yaz && dur_sec_s && bellek_yaz_veri[3]) begin
        hata_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Directed bench for bellek_yanitlayici: RAM, counter, status, TX FIFO, decode errors.
module tb_bellek_yanitlayici;

  logic        clk;
  logic        rst;
  logic [31:0] bellek_adres;
  logic [31:0] bellek_oku_veri;
  logic [31:0] bellek_yaz_veri;
  logic        bellek_yaz;
  logic [7:0]  cikis_veri;
  logic        cikis_gecerli;
  logic        cikis_hazir;
  logic        hata;

  int checks;
  int errors;

  localparam logic [31:0] SAY  = 32'hC000_0000;
  localparam logic [31:0] DUR  = 32'hC000_0004;
  localparam logic [31:0] TX   = 32'hC000_0008;
  localparam logic [31:0] BOSTA = 32'h8000_0000;

  bellek_yanitlayici dut (
    .clk             (clk),
    .rst             (rst),
    .bellek_adres    (bellek_adres),
    .bellek_oku_veri (bellek_oku_veri),
    .bellek_yaz_veri (bellek_yaz_veri),
    .bellek_yaz      (bellek_yaz),
    .cikis_veri      (cikis_veri),
    .cikis_gecerli   (cikis_gecerli),
    .cikis_hazir     (cikis_hazir),
    .hata            (hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle write strobe starting at a falling edge; address is left on addr.
  task automatic vur(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bellek_adres    = addr;
    bellek_yaz_veri = data;
    bellek_yaz      = 1'b1;
    @(negedge clk);
    bellek_yaz = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bellek_adres = DUR;
    bellek_yaz = 1'b0;
    bellek_yaz_veri = 32'h0;
    cikis_hazir = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_status got %h want %h", bellek_oku_veri, 32'h0000_0001);
    end
    checks++;
    if (cikis_gecerli !== 1'b0 || cikis_veri !== 8'h00 || hata !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got v=%b d=%h h=%b want 0 00 0", cikis_gecerli, cikis_veri, hata);
    end
    bellek_adres = SAY;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0) begin
      errors++; $display("FAIL reset_counter got %h want 0", bellek_oku_veri);
    end
    @(negedge clk);
    bellek_adres = BOSTA;
    rst = 1'b1;
  endtask

  task automatic test_ram;
    vur(32'h8000_0010, 32'hDEAD_BEEF);
    vur(32'h8000_0FFC, 32'h1234_5678);
    bellek_adres = 32'h8000_0010;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_read got %h want %h", bellek_oku_veri, 32'hDEAD_BEEF);
    end
    bellek_adres = 32'h8000_0013;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_read_unaligned got %h want %h", bellek_oku_veri, 32'hDEAD_BEEF);
    end
    bellek_adres = 32'h8000_0FFC;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h1234_5678) begin
      errors++; $display("FAIL ram_last_word got %h want %h", bellek_oku_veri, 32'h1234_5678);
    end
    bellek_adres = BOSTA;
  endtask

  task automatic test_counter;
    logic [31:0] v1;
    logic [31:0] v2;
    @(negedge clk);
    bellek_adres = SAY;
    #1;
    v1 = bellek_oku_veri;
    repeat (5) @(negedge clk);
    #1;
    v2 = bellek_oku_veri;
    checks++;
    if (v2 - v1 !== 32'd5) begin
      errors++; $display("FAIL counter_delta got %0d want 5", v2 - v1);
    end
    vur(SAY, 32'hFFFF_FFFE);
    #1;
    checks++;
    if (bellek_oku_veri !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL counter_load got %h want %h", bellek_oku_veri, 32'hFFFF_FFFE);
    end
    @(negedge clk); #1;
    checks++;
    if (bellek_oku_veri !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL counter_max got %h want %h", bellek_oku_veri, 32'hFFFF_FFFF);
    end
    @(negedge clk); #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0000) begin
      errors++; $display("FAIL counter_wrap got %h want 0", bellek_oku_veri);
    end
    bellek_adres = BOSTA;
  endtask

  task automatic test_fifo_overflow;
    cikis_hazir = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      vur(TX, 32'(i));
    end
    bellek_adres = DUR;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0806) begin
      errors++; $display("FAIL overflow_status got %h want %h", bellek_oku_veri, 32'h0000_0806);
    end
    @(negedge clk);
    cikis_hazir = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++;
      if (cikis_gecerli !== 1'b1 || cikis_veri !== 8'(i)) begin
        errors++; $display("FAIL drain_order got v=%b d=%h want 1 %h", cikis_gecerli, cikis_veri, 8'(i));
      end
      @(negedge clk);
    end
    cikis_hazir = 1'b0;
    #1;
    checks++;
    if (cikis_gecerli !== 1'b0 || bellek_oku_veri !== 32'h0000_0005) begin
      errors++; $display("FAIL drained_status got v=%b s=%h want 0 %h", cikis_gecerli, bellek_oku_veri, 32'h0000_0005);
    end
    vur(DUR, 32'h0000_0004);
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0001) begin
      errors++; $display("FAIL tasma_clear got %h want %h", bellek_oku_veri, 32'h0000_0001);
    end
  endtask

  task automatic test_strobe_hold;
    cikis_hazir = 1'b0;
    @(negedge clk);
    bellek_adres = TX;
    bellek_yaz_veri = 32'h0000_0041;
    bellek_yaz = 1'b1;
    repeat (3) @(negedge clk);
    bellek_yaz = 1'b0;
    bellek_adres = DUR;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0100 || cikis_veri !== 8'h41) begin
      errors++; $display("FAIL strobe_once got s=%h d=%h want %h 41", bellek_oku_veri, cikis_veri, 32'h0000_0100);
    end
    cikis_hazir = 1'b1;
    @(negedge clk);
    cikis_hazir = 1'b0;
    #1;
    checks++;
    if (cikis_gecerli !== 1'b0) begin
      errors++; $display("FAIL strobe_drain got v=%b want 0", cikis_gecerli);
    end
  endtask

  task automatic test_decode_error;
    @(negedge clk);
    bellek_adres = 32'h0000_0000;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0) begin
      errors++; $display("FAIL bad_read got %h want 0", bellek_oku_veri);
    end
    @(negedge clk);
    bellek_adres = 32'h8000_1000;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0 || hata !== 1'b1) begin
      errors++; $display("FAIL ram_past_end got d=%h h=%b want 0 1", bellek_oku_veri, hata);
    end
    @(negedge clk);
    bellek_adres = DUR;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0009) begin
      errors++; $display("FAIL hata_status got %h want %h", bellek_oku_veri, 32'h0000_0009);
    end
    vur(DUR, 32'h0000_0008);
    #1;
    checks++;
    if (hata !== 1'b0 || bellek_oku_veri !== 32'h0000_0001) begin
      errors++; $display("FAIL hata_clear got h=%b s=%h want 0 %h", hata, bellek_oku_veri, 32'h0000_0001);
    end
  endtask

  task automatic test_back_to_back;
    cikis_hazir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vur(TX, 32'h10 + 32'(i));
    end
    @(negedge clk);
    bellek_adres = TX;
    bellek_yaz_veri = 32'h0000_0099;
    bellek_yaz = 1'b1;
    cikis_hazir = 1'b1;
    #1;
    checks++;
    if (cikis_veri !== 8'h10) begin
      errors++; $display("FAIL full_head got %h want 10", cikis_veri);
    end
    @(negedge clk);
    bellek_yaz = 1'b0;
    cikis_hazir = 1'b0;
    bellek_adres = DUR;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'h0000_0802 || cikis_veri !== 8'h11) begin
      errors++; $display("FAIL full_push_pop got s=%h d=%h want %h 11", bellek_oku_veri, cikis_veri, 32'h0000_0802);
    end
    cikis_hazir = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (cikis_veri !== 8'h12) begin
      errors++; $display("FAIL mid_drain got %h want 12", cikis_veri);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (cikis_gecerli !== 1'b0 || cikis_veri !== 8'h00 || bellek_oku_veri !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_mid_drain got v=%b d=%h s=%h want 0 00 %h", cikis_gecerli, cikis_veri, bellek_oku_veri, 32'h0000_0001);
    end
    @(negedge clk);
    cikis_hazir = 1'b0;
    rst = 1'b1;
    bellek_adres = 32'h8000_0010;
    #1;
    checks++;
    if (bellek_oku_veri !== 32'hDEAD_BEEF || cikis_gecerli !== 1'b0) begin
      errors++; $display("FAIL ram_kept got d=%h v=%b want %h 0", bellek_oku_veri, cikis_gecerli, 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram();
    test_counter();
    test_fifo_overflow();
    test_strobe_hold();
    test_decode_error();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
